action_phv_assembler: RTL and testbench
=======================================

Name: action_phv_assembler

Overview:
- Downstream of the per-container ALUs in each action stage.
- Captures each ALU's container_out/container_out_valid result and pairs it with the metadata PHV segment that was dispatched with the action.
- Emits one reassembled PHV per packet to the next stage over a valid/ready handshake.
- Absorbs lane-to-lane skew in result arrival and buffers up to 4 in-flight metadata segments.

Parameters:
- STAGE_ID, 0, stage index; identification only, no functional effect.
- DATA_WIDTH, 48, container width; must match the ALU DATA_WIDTH.
- NUM_ALU, 8, number of ALU lanes (containers) collected per PHV.
- META_WIDTH, 256, width of the metadata segment passed around the ALUs.
- META_DEPTH, 4, metadata FIFO depth; power of two, at least 2.

Ports:
- clk  in  1  stage clock.
- rst  in  1  asynchronous, active-high reset; one clock domain only.
- meta_in  in  META_WIDTH  metadata segment of the PHV entering the ALUs.
- meta_in_valid  in  1  meta_in is valid this cycle.
- meta_in_ready  out  1  metadata FIFO can accept; equals ~full, combinational from the count.
- container_in  in  NUM_ALU*DATA_WIDTH  ALU results; lane i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- container_in_valid  in  NUM_ALU  per-lane result valid, one-cycle pulse per packet.
- phv_out  out  META_WIDTH+NUM_ALU*DATA_WIDTH  {meta, lane NUM_ALU-1 … lane 0}; meta occupies the MSBs.
- phv_out_valid  out  1  phv_out holds a complete PHV.
- phv_out_ready  in  1  downstream accepts phv_out this cycle.
- overflow_err  out  1  sticky flag: a lane delivered a result while its previous result was still held.
- pending_cnt  out  $clog2(META_DEPTH)+1  current metadata FIFO occupancy.

Behaviour:
- Reset (async, rst=1):
  - phv_out_valid=0, phv_out=0, overflow_err=0, pending_cnt=0.
  - captured mask=0, lane registers=0, state=COLLECT.
  - FIFO is emptied. An in-flight PHV is discarded, not emitted.
- Metadata FIFO:
  - Push when meta_in_valid & meta_in_ready. Pop on an accepted output (phv_out_valid & phv_out_ready).
  - Simultaneous push and pop leaves the count unchanged.
  - When full, meta_in_ready=0 even if a pop occurs in the same cycle.
  - Push while full is ignored; the upstream contract forbids it.
- Lane capture, every cycle, for each i:
  - If container_in_valid[i] & ~captured[i]: lane_r[i] <= container_in lane i and captured[i] <= 1.
  - If container_in_valid[i] & captured[i] (and the lane is not being released this cycle): data is dropped and overflow_err <= 1 until reset.
- State COLLECT:
  - Move to OUTPUT when captured is all-ones and the FIFO is non-empty, evaluated on registered values.
  - phv_out is registered on that same edge from the FIFO head and lane_r.
- Latency:
  - phv_out_valid rises 1 cycle after the edge that captured the last lane, given the FIFO is non-empty.
  - If metadata arrives after all lanes, phv_out_valid rises 1 cycle after the push edge.
- State OUTPUT:
  - phv_out_valid=1; phv_out is held stable until accepted.
  - On phv_out_ready: pop the FIFO, clear captured, state <= COLLECT, phv_out_valid <= 0.
  - A lane valid in the same cycle as acceptance is captured into the cleared slot; it belongs to the next PHV and is not an overflow.
- Throughput: at most one PHV every 2 cycles, matching the ALU's IDLE→OUTPUT cadence.
- Arithmetic: none. FIFO pointers wrap modulo META_DEPTH.

Decomposition:
- Shared action package: state localparams COLLECT=1'b0, OUTPUT=1'b1; a lane-slicing width constant; default widths.
- One sub-module: meta_fifo, a synchronous FIFO with parameters WIDTH and DEPTH and outputs full, empty and count.
- Lane capture and the state machine stay in the top module.

Test Plan:
- Reset mid-OUTPUT: assert rst with phv_out_valid=1 → phv_out_valid=0, pending_cnt=0 in the same cycle; no PHV emitted after rst drops.
- Aligned lanes: push meta=0xA5…, then all 8 lanes valid 1 cycle later with lane i = i+1 → phv_out_valid 1 cycle later; phv_out = {0xA5…, 8,7,…,1}.
- Skewed lanes: lanes 0-3 arrive at t, lanes 4-7 at t+3 → phv_out_valid at t+4; content is correct.
- Backpressure and overflow: hold phv_out_ready=0 for 5 cycles after valid → phv_out stable; a second pulse on lane 2 during the hold → overflow_err=1 and the held lane 2 value is unchanged.
- FIFO full: push 4 metas with no lanes → meta_in_ready=0, pending_cnt=4; deliver 4 lane sets with ready=1 → 4 PHVs in push order, then pending_cnt=0.
- Accept/capture overlap: all lanes valid in the same cycle phv_out_ready=1 accepts → next PHV is assembled from those values; overflow_err stays 0.

Source files
------------

// File: rtl/action_phv_assembler_pkg.sv
// Shared definitions for the action-stage PHV assembler: FSM encoding, default widths
// and the lane-slicing helper.
package action_phv_assembler_pkg;

  localparam logic COLLECT = 1'b0;
  localparam logic OUTPUT  = 1'b1;

  localparam int LANE_W           = 48;
  localparam int DEF_DATA_WIDTH   = LANE_W;
  localparam int DEF_NUM_ALU      = 8;
  localparam int DEF_META_WIDTH   = 256;
  localparam int DEF_META_DEPTH   = 4;

  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/action_phv_assembler_if.sv
// Bundle of the assembler's metadata, ALU-result and PHV-output signals.
// The master side drives inputs into the assembler; the slave side is the assembler.
interface action_phv_assembler_if #(
  parameter int DATA_WIDTH = 48,
  parameter int NUM_ALU    = 8,
  parameter int META_WIDTH = 256,
  parameter int META_DEPTH = 4
);

  logic [META_WIDTH-1:0]                    meta_in;
  logic                                     meta_in_valid;
  logic                                     meta_in_ready;
  logic [NUM_ALU*DATA_WIDTH-1:0]            container_in;
  logic [NUM_ALU-1:0]                       container_in_valid;
  logic [META_WIDTH+NUM_ALU*DATA_WIDTH-1:0] phv_out;
  logic                                     phv_out_valid;
  logic                                     phv_out_ready;
  logic                                     overflow_err;
  logic [$clog2(META_DEPTH):0]              pending_cnt;

  modport master (
    output meta_in, meta_in_valid, container_in, container_in_valid, phv_out_ready,
    input  meta_in_ready, phv_out, phv_out_valid, overflow_err, pending_cnt
  );

  modport slave (
    input  meta_in, meta_in_valid, container_in, container_in_valid, phv_out_ready,
    output meta_in_ready, phv_out, phv_out_valid, overflow_err, pending_cnt
  );

endinterface

// File: rtl/action_phv_assembler_meta_fifo.sv
// Synchronous FIFO holding metadata segments while their ALU results are in flight.
// Push while full and pop while empty are ignored.
module meta_fifo #(
  parameter int WIDTH = 256,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];
  assign count   = cnt;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/action_phv_assembler.sv
// Collects one result per ALU lane, pairs them with the queued metadata segment and
// emits the reassembled PHV over a valid/ready handshake.
module action_phv_assembler
  import action_phv_assembler_pkg::*;
#(
  parameter int STAGE_ID   = 0,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_ALU    = DEF_NUM_ALU,
  parameter int META_WIDTH = DEF_META_WIDTH,
  parameter int META_DEPTH = DEF_META_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  action_phv_assembler_if.slave bus
);

  localparam int CW    = $clog2(META_DEPTH) + 1;
  localparam int LANES = NUM_ALU * DATA_WIDTH;

  if (META_DEPTH < 2 || (META_DEPTH & (META_DEPTH - 1)) != 0 || STAGE_ID < 0) begin : g_param_check
    $error("action_phv_assembler: META_DEPTH must be a power of two >= 2");
  end

  logic                          state;
  logic                          state_next;
  logic [NUM_ALU-1:0]            captured_p0;
  logic [DATA_WIDTH-1:0]         lane_p0 [NUM_ALU];
  logic                          overflow_p0;
  logic [META_WIDTH+LANES-1:0]   phv_p1;
  logic [LANES-1:0]              lanes_flat;

  logic                          fifo_full;
  logic                          fifo_empty;
  logic [META_WIDTH-1:0]         fifo_head;
  logic [CW-1:0]                 fifo_count;

  logic                          phv_valid;
  logic                          accept;
  logic                          load_phv;

  meta_fifo #(
    .WIDTH (META_WIDTH),
    .DEPTH (META_DEPTH)
  ) u_meta_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.meta_in_valid & ~fifo_full),
    .din   (bus.meta_in),
    .pop   (accept),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    lanes_flat = '0;
    for (int i = 0; i < NUM_ALU; i++) begin
      lanes_flat[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH] = lane_p0[i];
    end
  end

  // Stage p0: per-lane capture; an accept frees every slot in the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      captured_p0 <= '0;
      overflow_p0 <= 1'b0;
      for (int i = 0; i < NUM_ALU; i++) lane_p0[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_ALU; i++) begin
        if (accept) begin
          captured_p0[i] <= bus.container_in_valid[i];
          if (bus.container_in_valid[i])
            lane_p0[i] <= bus.container_in[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH];
        end else if (bus.container_in_valid[i]) begin
          if (!captured_p0[i]) begin
            lane_p0[i]     <= bus.container_in[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH];
            captured_p0[i] <= 1'b1;
          end else begin
            overflow_p0 <= 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= COLLECT;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      COLLECT: if ((&captured_p0) && !fifo_empty) state_next = OUTPUT;
      OUTPUT:  if (bus.phv_out_ready)             state_next = COLLECT;
      default: state_next = COLLECT;
    endcase
  end

  always_comb begin
    phv_valid = (state == OUTPUT);
    accept    = phv_valid & bus.phv_out_ready;
    load_phv  = (state == COLLECT) & (&captured_p0) & ~fifo_empty;
  end

  // Stage p1: PHV register, loaded on the COLLECT->OUTPUT edge and held until accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           phv_p1 <= '0;
    else if (load_phv) phv_p1 <= {fifo_head, lanes_flat};
  end

  assign bus.meta_in_ready = ~fifo_full;
  assign bus.phv_out       = phv_p1;
  assign bus.phv_out_valid = phv_valid;
  assign bus.overflow_err  = overflow_p0;
  assign bus.pending_cnt   = fifo_count;

endmodule

// File: tb/tb_action_phv_assembler.sv
// Randomised and directed bench for action_phv_assembler against a packet-level model.
module tb_action_phv_assembler;

  localparam int DW = 48;
  localparam int NA = 8;
  localparam int MW = 256;
  localparam int MD = 4;
  localparam int LW = NA * DW;
  localparam int PW = MW + LW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  action_phv_assembler_if #(.DATA_WIDTH(DW), .NUM_ALU(NA), .META_WIDTH(MW), .META_DEPTH(MD)) bus ();

  action_phv_assembler #(.STAGE_ID(0), .DATA_WIDTH(DW), .NUM_ALU(NA), .META_WIDTH(MW), .META_DEPTH(MD))
    dut (.clk(clk), .rst(rst), .bus(bus));

  // Packet-level model: metadata queue, per-lane pending result, one output slot.
  logic [MW-1:0] m_q[$];
  logic [DW-1:0] m_lane [NA];
  bit            m_have [NA];
  bit            m_busy;
  bit            m_ovf;
  logic [PW-1:0] m_phv;
  bit            m_acc, m_fire, m_room, m_all;
  logic [LW-1:0] m_cat;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      for (int i = 0; i < NA; i++) begin m_lane[i] = '0; m_have[i] = 0; end
      m_busy = 0; m_ovf = 0; m_phv = '0;
    end else begin
      m_acc  = m_busy && bus.phv_out_ready;
      m_room = m_q.size() < MD;
      m_all  = 1;
      for (int i = 0; i < NA; i++) begin
        if (!m_have[i]) m_all = 0;
        m_cat[i*DW +: DW] = m_lane[i];
      end
      m_fire = !m_busy && m_all && m_q.size() > 0;
      if (m_fire) m_phv = {m_q[0], m_cat};
      for (int i = 0; i < NA; i++) begin
        if (m_acc) m_have[i] = 0;
        if (bus.container_in_valid[i]) begin
          if (!m_have[i]) begin
            m_lane[i] = bus.container_in[i*DW +: DW];
            m_have[i] = 1;
          end else m_ovf = 1;
        end
      end
      if (m_acc) void'(m_q.pop_front());
      if (bus.meta_in_valid && m_room) m_q.push_back(bus.meta_in);
      if (m_fire) m_busy = 1;
      else if (m_acc) m_busy = 0;
    end
  end

  task automatic chk(input string name, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("m_valid", PW'(bus.phv_out_valid), PW'(m_busy));
      chk("m_ready", PW'(bus.meta_in_ready), PW'(m_q.size() < MD));
      chk("m_pending", PW'(bus.pending_cnt), PW'(m_q.size()));
      chk("m_overflow", PW'(bus.overflow_err), PW'(m_ovf));
      if (m_busy) chk("m_phv", bus.phv_out, m_phv);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.meta_in_valid      = 1'b0;
    bus.container_in_valid = '0;
    bus.phv_out_ready      = 1'b0;
  endtask

  task automatic push_meta(input logic [MW-1:0] m);
    bus.meta_in = m; bus.meta_in_valid = 1'b1;
    tick();
    bus.meta_in_valid = 1'b0;
  endtask

  task automatic drive_lanes(input logic [NA-1:0] mask, input logic [LW-1:0] data);
    bus.container_in = data; bus.container_in_valid = mask;
    tick();
    bus.container_in_valid = '0;
  endtask

  task automatic wait_valid(input int max);
    int n = 0;
    while (!bus.phv_out_valid && n < max) begin tick(); n++; end
    checks++;
    if (!bus.phv_out_valid) begin
      failures++;
      $display("FAIL wait_valid timeout after %0d cycles got=0 exp=1", max);
    end
  endtask

  task automatic accept_one();
    bus.phv_out_ready = 1'b1;
    tick();
    bus.phv_out_ready = 1'b0;
  endtask

  function automatic logic [LW-1:0] lane_set(input int base);
    logic [LW-1:0] v;
    for (int i = 0; i < NA; i++) v[i*DW +: DW] = DW'(base + i);
    return v;
  endfunction

  logic [MW-1:0] meta_a5, metas [4];
  logic [LW-1:0] lanes_a, lanes_b;
  logic [PW-1:0] held;

  initial begin
    bus.meta_in = '0; bus.container_in = '0;
    clear_inputs();
    meta_a5 = {32{8'hA5}};
    repeat (3) tick();
    chk("reset_valid", PW'(bus.phv_out_valid), PW'(0));
    chk("reset_phv", bus.phv_out, '0);
    rst = 1'b0;
    tick();
    chk("reset_pending", PW'(bus.pending_cnt), PW'(0));
    chk("reset_ready", PW'(bus.meta_in_ready), PW'(1));

    // Aligned lanes: lane i = i+1.
    push_meta(meta_a5);
    drive_lanes('1, lane_set(1));
    chk("aligned_not_yet", PW'(bus.phv_out_valid), PW'(0));
    tick();
    chk("aligned_valid", PW'(bus.phv_out_valid), PW'(1));
    chk("aligned_phv", bus.phv_out,
        {meta_a5, 48'd8, 48'd7, 48'd6, 48'd5, 48'd4, 48'd3, 48'd2, 48'd1});
    accept_one();
    chk("aligned_drain", PW'(bus.pending_cnt), PW'(0));

    // Capture in the same cycle as acceptance belongs to the next PHV.
    push_meta({32{8'h11}});
    push_meta({32{8'h22}});
    drive_lanes('1, lane_set(16'h100));
    wait_valid(3);
    lanes_b = lane_set(16'h200);
    bus.container_in = lanes_b; bus.container_in_valid = '1; bus.phv_out_ready = 1'b1;
    tick();
    clear_inputs();
    wait_valid(3);
    chk("overlap_phv", bus.phv_out, {{32{8'h22}}, lanes_b});
    chk("overlap_no_ovf", PW'(bus.overflow_err), PW'(0));
    accept_one();

    // Skewed lanes: 0-3 at t, 4-7 at t+3, valid at t+4.
    push_meta({32{8'h5A}});
    lanes_a = lane_set(16'h300);
    drive_lanes(8'h0F, lanes_a);
    tick(); tick();
    drive_lanes(8'hF0, lanes_a);
    chk("skew_not_yet", PW'(bus.phv_out_valid), PW'(0));
    tick();
    chk("skew_valid", PW'(bus.phv_out_valid), PW'(1));
    chk("skew_phv", bus.phv_out, {{32{8'h5A}}, lanes_a});
    accept_one();

    // FIFO full, then drain in push order.
    for (int k = 0; k < 4; k++) begin
      metas[k] = {32{8'(8'h40 + k)}};
      push_meta(metas[k]);
    end
    chk("full_ready", PW'(bus.meta_in_ready), PW'(0));
    chk("full_pending", PW'(bus.pending_cnt), PW'(4));
    for (int k = 0; k < 4; k++) begin
      drive_lanes('1, lane_set(k * 16));
      wait_valid(3);
      chk("full_order", bus.phv_out, {metas[k], lane_set(k * 16)});
      accept_one();
    end
    chk("full_empty", PW'(bus.pending_cnt), PW'(0));

    // Backpressure with a second pulse on lane 2.
    push_meta({32{8'h77}});
    drive_lanes('1, lane_set(16'h500));
    wait_valid(3);
    held = bus.phv_out;
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin
        bus.container_in = '0;
        bus.container_in[2*DW +: DW] = 48'hDEAD_BEEF_0001;
        bus.container_in_valid = 8'h04;
      end
      tick();
      bus.container_in_valid = '0;
      chk("hold_stable", bus.phv_out, held);
    end
    chk("hold_ovf", PW'(bus.overflow_err), PW'(1));
    chk("hold_lane2", PW'(bus.phv_out[2*DW +: DW]), PW'(48'h502));
    accept_one();

    // Reset while a PHV is presented.
    push_meta({32{8'h99}});
    drive_lanes('1, lane_set(16'h600));
    wait_valid(3);
    rst = 1'b1;
    #1;
    chk("rst_mid_valid", PW'(bus.phv_out_valid), PW'(0));
    chk("rst_mid_pending", PW'(bus.pending_cnt), PW'(0));
    chk("rst_mid_ovf", PW'(bus.overflow_err), PW'(0));
    tick(); tick();
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("rst_no_emit", PW'(bus.phv_out_valid), PW'(0));
    end

    // Randomised traffic against the model.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int w = 0; w < MW / 32; w++) bus.meta_in[w*32 +: 32] = $urandom;
      for (int w = 0; w < LW / 32; w++) bus.container_in[w*32 +: 32] = $urandom;
      bus.meta_in_valid = ($urandom_range(0, 2) == 0) && (m_q.size() < MD);
      for (int i = 0; i < NA; i++) bus.container_in_valid[i] = ($urandom_range(0, 3) == 0);
      bus.phv_out_ready = $urandom_range(0, 1);
      tick();
    end
    clear_inputs();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
